// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and sizing helpers for the direct-mapped data cache
package dcache_pkg;
  localparam int N_LINES = 16;
  localparam int N_AW = 16;
  localparam int N_DW = 16;
  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction
  function automatic int tag_w(input int lines, input int aw);
    return aw - idx_w(lines);
  endfunction
  localparam int N_TW = tag_w(N_LINES, N_AW);
  typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_t;
  typedef struct packed {
    logic valid;
    logic [N_TW-1:0] tag;
    logic [N_DW-1:0] data;
  } line_t;
endpackage

// File: rtl/dcache_array.sv
// dcache_array: tag/data line storage, async read, sync write, sync clear of all valid bits
module dcache_array
  import dcache_pkg::*;
#(
  parameter int LINES = N_LINES
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic wr,
  input  logic [idx_w(LINES)-1:0] ridx,
  input  logic [idx_w(LINES)-1:0] widx,
  input  line_t wline,
  output line_t rline
);
  line_t mem [LINES];
  assign rline = mem[ridx];
  // clear follows the write so a fill coinciding with invalidate lands invalid
  always_ff @(posedge clk) begin
    if (wr) mem[widx] <= wline;
    if (rst || clr) for (int i = 0; i < LINES; i++) mem[i].valid <= 1'b0;
  end
endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: write-through no-write-allocate cache controller with stall and hit/miss counters
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int LINES = N_LINES,
  parameter int AW = N_AW,
  parameter int DW = N_DW
) (
  input  logic clk,
  input  logic rst,
  input  logic re,
  input  logic we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic stall,
  input  logic inval,
  output logic mem_re,
  output logic mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic mem_rdy,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
);
  localparam int IW = idx_w(LINES);
  state_t state, next;
  line_t line, wline;
  logic hit, ld, st, clr, wr, fill_pend, st_done, inval_pend;
  assign ld = re && !we;
  assign st = we;
  assign hit = line.valid && line.tag == addr[AW-1:IW];
  assign rdata = hit ? line.data : '0;
  assign mem_addr = addr;
  assign mem_wdata = wdata;
  assign clr = state == IDLE ? inval : mem_rdy && (inval || inval_pend);
  assign wr = mem_rdy && (state == RD_MISS || (state == WR_THRU && hit));
  assign wline = {1'b1, addr[AW-1:IW], state == RD_MISS ? mem_rdata : wdata};
  dcache_array #(.LINES(LINES)) u_array (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .wr(wr),
    .ridx(addr[IW-1:0]),
    .widx(addr[IW-1:0]),
    .wline(wline),
    .rline(line)
  );
  always_ff @(posedge clk) state <= rst ? IDLE : next;
  // st_done lets the held store retire for one cycle instead of restarting
  always_comb begin
    next = state;
    if (state == IDLE) next = st && !st_done ? WR_THRU : ld && !hit ? RD_MISS : IDLE;
    else next = mem_rdy ? IDLE : state;
  end
  always_comb begin
    stall = !rst && (state != IDLE || (st && !st_done) || (ld && !hit));
    mem_re = state == RD_MISS;
    mem_we = state == WR_THRU;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt <= '0;
      miss_cnt <= '0;
      fill_pend <= 1'b0;
      st_done <= 1'b0;
      inval_pend <= 1'b0;
    end else begin
      fill_pend <= state == IDLE ? ld && !hit : fill_pend;
      st_done <= state == WR_THRU && mem_rdy;
      inval_pend <= state != IDLE && !mem_rdy && (inval || inval_pend);
      if (state == IDLE && ld && hit && !fill_pend && hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
      if (state == IDLE && ld && !hit && miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: randomized scoreboard bench with a behavioural cache and memory model
module tb_dcache_ctrl;
  logic clk = 0, rst = 1, re = 0, we = 0, inval = 0;
  logic [15:0] addr = 0, wdata = 0, mem_rdata = 0;
  logic [15:0] rdata, mem_addr, mem_wdata, hit_cnt, miss_cnt;
  logic stall, mem_re, mem_we, mem_rdy, rdy_q = 0, stray = 0;
  assign mem_rdy = rdy_q | stray;
  always #5 clk = ~clk;

  dcache_ctrl dut (
    .clk(clk), .rst(rst), .re(re), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .stall(stall), .inval(inval), .mem_re(mem_re), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_rdy(mem_rdy), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  typedef struct {
    bit st;
    logic [15:0] rdata;
    int stall;
    logic [15:0] hits;
    logic [15:0] misses;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;
  logic [15:0] mem [65536];
  logic [15:0] ref_mem [65536];
  bit rv [16];
  logic [11:0] rt [16];
  logic [15:0] hits = 0, misses = 0;
  int lat = 1, cnt = 0, sc = 0, errors = 0, checks = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, req, $time);
    end
  endtask

  function automatic logic [15:0] inc(input logic [15:0] v);
    return v == 16'hFFFF ? v : v + 16'd1;
  endfunction

  // memory responds lat cycles after the strobe first appears
  always @(posedge clk) begin
    rdy_q <= 0;
    if (rst) cnt <= 0;
    else if ((mem_re || mem_we) && !mem_rdy) begin
      if (cnt + 1 >= lat) begin
        rdy_q <= 1;
        mem_rdata <= mem[mem_addr];
        if (mem_we) mem[mem_addr] <= mem_wdata;
        cnt <= 0;
      end else cnt <= cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (rst) sc = 0;
    else begin
      if (mem_re || mem_we) chk("mem_addr", mem_addr, addr);
      if (mem_we) chk("mem_wdata", mem_wdata, wdata);
      if (re || we) begin
        if (stall) sc++;
        else begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL retire: got unexpected retire expected none at %0t", $time);
          end else begin
            mon_e = q.pop_front();
            chk("stall_cycles", sc, mon_e.stall);
            if (!mon_e.st) chk("rdata", rdata, mon_e.rdata);
            chk("hit_cnt", hit_cnt, mon_e.hits);
            chk("miss_cnt", miss_cnt, mon_e.misses);
          end
          sc = 0;
        end
      end
    end
  end

  task automatic do_req(input bit st, input logic [15:0] a, input logic [15:0] d, input int l, input bit inj);
    exp_t e;
    int idx = int'(a[3:0]);
    bit h = rv[idx] && rt[idx] == a[15:4];
    bit ij = inj && !st && !h;
    bit done = 0;
    e.st = st;
    e.rdata = ref_mem[a];
    e.stall = 0;
    if (st) begin
      ref_mem[a] = d;
      e.stall = l + 2;
    end else if (!h) begin
      misses = inc(misses);
      e.stall = l + 2;
      if (ij) begin
        misses = inc(misses);
        e.stall = 2 * (l + 2);
        rv = '{default: 0};
      end
      rv[idx] = 1;
      rt[idx] = a[15:4];
    end
    e.hits = hits;
    e.misses = misses;
    if (!st && h) hits = inc(hits);
    q.push_back(e);
    lat = l;
    re = !st;
    we = st;
    addr = a;
    wdata = d;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      inval = 0;
      if (!stall) done = 1;
      else if (ij && k == 1) inval = 1;
    end
    if (!done) begin
      $display("FAIL timeout: got stall stuck expected release at %0t", $time);
      $fatal(1);
    end
    @(posedge clk);
    #1;
    re = 0;
    we = 0;
  endtask

  task automatic idle_inval();
    inval = 1;
    rv = '{default: 0};
    @(posedge clk);
    #1;
    inval = 0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 16'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[16'h0023] = 16'hBEEF;
    ref_mem[16'h0023] = 16'hBEEF;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("rst_rdata", rdata, 0);
    chk("rst_stall", stall, 0);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    @(posedge clk);
    #1;
    do_req(0, 16'h0023, 0, 3, 0);
    do_req(0, 16'h0023, 0, 2, 0);
    do_req(0, 16'h0013, 0, 2, 0);
    do_req(0, 16'h0023, 0, 1, 0);
    do_req(0, 16'h0013, 0, 1, 0);
    do_req(1, 16'h0013, 16'h1234, 2, 0);
    do_req(0, 16'h0013, 0, 2, 0);
    do_req(1, 16'h0040, 16'h5A5A, 2, 0);
    do_req(0, 16'h0040, 0, 2, 0);
    do_req(0, 16'h0005, 0, 3, 1);
    do_req(0, 16'h0013, 0, 1, 0);
    do_req(0, 16'h0005, 0, 1, 0);
    for (int n = 0; n < 400; n++) begin
      logic [15:0] a = $urandom_range(0, 9) == 0 ? 16'($urandom) : 16'($urandom_range(0, 63));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      if ($urandom_range(0, 19) == 0) idle_inval();
      do_req($urandom_range(0, 9) < 3, a, 16'($urandom), $urandom_range(1, 4), $urandom_range(0, 6) == 0);
    end
    idle_inval();
    re = 1;
    addr = 16'h0077;
    lat = 3;
    @(posedge clk);
    #1;
    rst = 1;
    re = 0;
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("rstmid_mem_re", mem_re, 0);
    chk("rstmid_stall", stall, 0);
    chk("rstmid_hit_cnt", hit_cnt, 0);
    chk("rstmid_miss_cnt", miss_cnt, 0);
    @(posedge clk);
    #1;
    stray = 1;
    @(posedge clk);
    #1;
    stray = 0;
    @(negedge clk);
    chk("stray_stall", stall, 0);
    chk("stray_mem_re", mem_re, 0);
    chk("stray_miss_cnt", miss_cnt, 0);
    rv = '{default: 0};
    hits = 0;
    misses = 0;
    @(posedge clk);
    #1;
    do_req(0, 16'h0077, 0, 2, 0);
    for (int k = 0; k < 50 && q.size() != 0; k++) @(posedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
Direct-mapped, write-through, no-write-allocate data cache between the CPU MEM stage and a multi-cycle main data memory. It serves MEM-stage loads and stores. It raises a stall so the pipeline freezes during misses and write-throughs. Hit/miss counters are kept for performance debug.

Parameters:
LINES, 16, number of one-word cache lines (power of 2, >=2)
AW, 16, address width (word addresses)
DW, 16, data width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
re  in  1  load request from MEM stage, held stable while stall=1
we  in  1  store request from MEM stage, held stable while stall=1
addr  in  AW  word address of request
wdata  in  DW  store data
rdata  out  DW  load data, valid when re=1 and stall=0
stall  out  1  freeze pipeline; combinational
inval  in  1  invalidate all lines (one-cycle pulse)
mem_re  out  1  main-memory read strobe
mem_we  out  1  main-memory write strobe
mem_addr  out  AW  main-memory address
mem_wdata  out  DW  main-memory write data
mem_rdata  in  DW  main-memory read data, valid with mem_rdy
mem_rdy  in  1  main-memory completion, one-cycle pulse, >=1 cycle after strobe
hit_cnt  out  16  saturating load-hit counter
miss_cnt  out  16  saturating load-miss counter

Behaviour:
- IDX = log2(LINES); index = addr[IDX-1:0]; tag = addr[AW-1:IDX]; per line: valid bit, tag, data word.
- Reset: all valid bits 0, state IDLE, counters 0, mem_re=mem_we=0, stall=0, rdata=0.
- re and we both asserted is illegal; we takes priority (request treated as a store).
- FSM states: IDLE, RD_MISS, WR_THRU.
- IDLE, load hit: rdata = line data in the same cycle, stall=0, hit_cnt+1.
- IDLE, load miss: stall=1 combinationally, miss_cnt+1, next state RD_MISS.
- RD_MISS: mem_re=1, mem_addr=addr, stall=1. On mem_rdy, write valid/tag/data and return to IDLE. The held request then hits next cycle (total miss penalty = memory latency + 2). That replay hit does not increment hit_cnt; a flag set on entering RD_MISS suppresses it.
- IDLE, store: stall=1, next state WR_THRU.
- WR_THRU: mem_we=1, mem_addr=addr, mem_wdata=wdata, stall=1. On mem_rdy, return to IDLE with stall=0 for one cycle so the store retires. If the line hit (valid and tag match), the line data is updated on mem_rdy. On a store miss, the cache is unchanged.
- Strobes are level signals held until mem_rdy. They drop the cycle after mem_rdy.
- inval: clears all valid bits at the next edge and is honoured only in IDLE. If asserted in RD_MISS or WR_THRU, it is latched and applied on the return to IDLE, after the fill. The fill result then becomes invalid, and the replayed load misses again.
- Counters saturate at 16'hFFFF; no wrap.
- Reset mid-miss or mid-write: FSM goes to IDLE at once and strobes drop the next cycle. A late mem_rdy arriving in IDLE is ignored.
- A re/we pulse with neither asserted does nothing; stall=0.

Decomposition:
- Shared package dcache_pkg: state enum (IDLE, RD_MISS, WR_THRU), the IDX/tag-width derivation function, and a line struct {valid, tag, data}.
- One sub-module, dcache_array: LINES-entry tag/data storage with one combinational read port, one synchronous write port, and a synchronous clear-all for valid bits. The FSM and counters live in dcache_ctrl.

Test Plan:
- Cold load: re=1, addr=16'h0023, memory returns 16'hBEEF after 3 cycles -> stall high 5 cycles; mem_re asserted with mem_addr=0x0023; then rdata=BEEF, stall=0, miss_cnt=1, hit_cnt=0.
- Repeat load at 0x0023 -> same-cycle rdata=BEEF, stall=0, hit_cnt=1, no mem_re.
- Conflict: load 0x0013 (same index 3, different tag) -> miss and refill. A following load of 0x0023 misses again (miss_cnt=3).
- Store hit: we=1, addr=0x0013, wdata=16'h1234, memory latency 2 -> mem_we with data 0x1234; stall released after mem_rdy. A load of 0x0013 then hits with 0x1234. A store to uncached 0x0040 leaves 0x0040 a miss on the next load.
- inval pulsed during RD_MISS for 0x0005 -> fill completes, the replayed load misses and refetches, and all previously valid lines now miss.
- rst asserted 1 cycle into RD_MISS -> next cycle mem_re=0, stall=0, counters 0; a later stray mem_rdy changes nothing.
